// File: rtl/link_dma_framer.sv
// Optical-link receive framer: cuts the 32-bit word stream into K-delimited frames,
// packs word pairs into 64-bit beats and queues header/data/trailer beats for the DMA stream.
module link_dma_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                          dmaClk,
  input  logic                          dmaRstL,
  input  logic                          enable,
  input  logic [31:0]                   linkData,
  input  logic [3:0]                    linkK,
  input  logic                          linkValid,
  output logic                          obTValid,
  output logic [63:0]                   obTData,
  output logic [7:0]                    obTKeep,
  output logic                          obTLast,
  input  logic                          obTReady,
  output logic [15:0]                   frameSeq,
  output logic [15:0]                   dropCnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [16:0]   MAXW     = 17'(MAX_WORDS);
  localparam logic [CW-1:0] ROOM_MAX = CW'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_WAIT, S_FRAME, S_TRAIL} state_t;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  state_t        state_q, state_d;
  logic          in_v_q;
  logic [31:0]   in_d_q;
  logic [3:0]    in_k_q;
  logic [31:0]   acc_q, acc_d;
  logic          half_q, half_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          ovf_q, ovf_d, prot_q, prot_d, trunc_q, trunc_d;
  logic [15:0]   seq_q, seq_d, drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, drop_inc, room;
  beat_t         push_beat, head;
  beat_t         mem_q [FIFO_DEPTH];

  logic is_ctl, is_sof, is_eof, is_idle, is_data, is_badk;

  assign is_ctl  = in_v_q && (in_k_q == 4'b0001);
  assign is_sof  = is_ctl && (in_d_q[7:0] == 8'h3C);
  assign is_eof  = is_ctl && (in_d_q[7:0] == 8'hDC);
  assign is_idle = is_ctl && (in_d_q[7:0] == 8'hBC);
  assign is_data = in_v_q && (in_k_q == 4'b0000);
  assign is_badk = in_v_q && !is_data && !is_sof && !is_eof && !is_idle;

  // Registered count only: a pop in the same cycle does not create room.
  assign room = (cnt_q <= ROOM_MAX);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    half_d     = half_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    prot_d     = prot_q;
    trunc_d    = trunc_q;
    seq_d      = seq_q;
    drop_inc   = 1'b0;
    push       = 1'b0;
    push_beat  = '0;
    case (state_q)
      S_WAIT: begin
        if (is_sof && enable) begin
          if (room) begin
            push      = 1'b1;
            push_beat = '{last: 1'b0, keep: 8'hFF, data: {seq_q, 16'h0, 8'h0, in_d_q[31:8]}};
            seq_d     = seq_q + 16'd1;
            state_d   = S_FRAME;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      S_FRAME: begin
        if (is_data) begin
          if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
          if ({1'b0, word_cnt_q} >= MAXW) begin
            trunc_d = 1'b1;
          end else if (!half_q) begin
            acc_d  = in_d_q;
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (room) begin
              push      = 1'b1;
              push_beat = '{last: 1'b0, keep: 8'hFF, data: {in_d_q, acc_q}};
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (is_badk) begin
          prot_d = 1'b1;
        end else if (is_eof || is_sof) begin
          // A SOF inside a frame closes it like EOF; the new frame is lost.
          if (is_sof) begin
            prot_d   = 1'b1;
            drop_inc = 1'b1;
          end
          if (half_q) begin
            if (room) begin
              push      = 1'b1;
              push_beat = '{last: 1'b0, keep: 8'h0F, data: {32'h0, acc_q}};
            end else begin
              ovf_d = 1'b1;
            end
          end
          half_d  = 1'b0;
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        push       = 1'b1;
        push_beat  = '{last: 1'b1, keep: 8'hFF,
                       data: {32'h0, 13'h0, ovf_q, prot_q, trunc_q, word_cnt_q}};
        ovf_d      = 1'b0;
        prot_d     = 1'b0;
        trunc_d    = 1'b0;
        word_cnt_d = '0;
        acc_d      = '0;
        half_d     = 1'b0;
        state_d    = S_WAIT;
        if (is_sof) drop_inc = 1'b1;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    pop      = (cnt_q != '0) && obTReady;
    drop_d   = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_ff @(posedge dmaClk or negedge dmaRstL) begin
    if (!dmaRstL) begin
      state_q    <= S_WAIT;
      in_v_q     <= 1'b0;
      in_d_q     <= '0;
      in_k_q     <= '0;
      acc_q      <= '0;
      half_q     <= 1'b0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      prot_q     <= 1'b0;
      trunc_q    <= 1'b0;
      seq_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_v_q     <= linkValid;
      in_d_q     <= linkData;
      in_k_q     <= linkK;
      acc_q      <= acc_d;
      half_q     <= half_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      prot_q     <= prot_d;
      trunc_q    <= trunc_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Beat storage needs no reset; the occupancy count qualifies it.
  always_ff @(posedge dmaClk) begin
    if (push) mem_q[wr_ptr_q] <= push_beat;
  end

  assign head      = mem_q[rd_ptr_q];
  assign obTValid  = (cnt_q != '0);
  assign obTData   = obTValid ? head.data : '0;
  assign obTKeep   = obTValid ? head.keep : '0;
  assign obTLast   = obTValid && head.last;
  assign frameSeq  = seq_q;
  assign dropCnt   = drop_q;
  assign fifoCount = cnt_q;

endmodule

// File: tb/tb_link_dma_framer.sv
// Bench for link_dma_framer: a queue-based model checked every cycle, plus literal
// expectations on captured output beats for each directed scenario.
module tb_link_dma_framer;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b1;
  logic [31:0] link_data = '0;
  logic [3:0]  link_k = '0;
  logic link_valid = 1'b0;
  logic ready = 1'b0;
  logic tsel = 1'b0;

  logic        ob_valid, ob_last;
  logic [63:0] ob_data;
  logic [7:0]  ob_keep;
  logic [15:0] frame_seq, drop_cnt;
  logic [4:0]  fifo_count;

  logic        t_valid, t_last;
  logic [63:0] t_data;
  logic [7:0]  t_keep;
  logic [15:0] t_seq, t_drop;
  logic [4:0]  t_count;
  logic        t_link_valid;

  assign t_link_valid = link_valid & tsel;

  always #5 clk = ~clk;

  link_dma_framer #(.FIFO_DEPTH(16), .MAX_WORDS(1024)) dut (
    .dmaClk(clk), .dmaRstL(rst_n), .enable(enable),
    .linkData(link_data), .linkK(link_k), .linkValid(link_valid),
    .obTValid(ob_valid), .obTData(ob_data), .obTKeep(ob_keep), .obTLast(ob_last),
    .obTReady(ready), .frameSeq(frame_seq), .dropCnt(drop_cnt), .fifoCount(fifo_count)
  );

  link_dma_framer #(.FIFO_DEPTH(16), .MAX_WORDS(4)) dut_t (
    .dmaClk(clk), .dmaRstL(rst_n), .enable(1'b1),
    .linkData(link_data), .linkK(link_k), .linkValid(t_link_valid),
    .obTValid(t_valid), .obTData(t_data), .obTKeep(t_keep), .obTLast(t_last),
    .obTReady(1'b1), .frameSeq(t_seq), .dropCnt(t_drop), .fifoCount(t_count)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the FIFO is a queue of expected beats; a frame is tracked as a word count,
  // a pending unpaired word and the three status flags.
  beat_t       exp_q[$];
  logic        m_v = 1'b0;
  logic [31:0] m_d = '0;
  logic [3:0]  m_k = '0;
  bit          in_frame = 0, trail_due = 0, pend_v = 0;
  logic [31:0] pend = '0;
  bit          m_ovf = 0, m_prot = 0, m_trunc = 0;
  logic [15:0] m_words = '0, m_seq = '0, m_drop = '0;
  int          m_free;
  bit          w_sof, w_eof, w_dat, w_bad, w_ctl;

  function automatic void m_dropinc();
    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_v = 0; in_frame = 0; trail_due = 0; pend_v = 0;
      m_ovf = 0; m_prot = 0; m_trunc = 0;
      m_words = '0; m_seq = '0; m_drop = '0;
    end else begin
      m_free = 16 - exp_q.size();
      if (exp_q.size() > 0 && ready) void'(exp_q.pop_front());
      w_ctl = m_v && m_k == 4'b0001;
      w_sof = w_ctl && m_d[7:0] == 8'h3C;
      w_eof = w_ctl && m_d[7:0] == 8'hDC;
      w_dat = m_v && m_k == 4'b0000;
      w_bad = m_v && !w_dat && !w_sof && !w_eof && !(w_ctl && m_d[7:0] == 8'hBC);
      if (trail_due) begin
        exp_q.push_back('{1'b1, 8'hFF, {45'h0, m_ovf, m_prot, m_trunc, m_words}});
        trail_due = 0; in_frame = 0; pend_v = 0;
        m_ovf = 0; m_prot = 0; m_trunc = 0; m_words = '0;
        if (w_sof) m_dropinc();
      end else if (!in_frame) begin
        if (w_sof && enable) begin
          if (m_free >= 2) begin
            exp_q.push_back('{1'b0, 8'hFF, {m_seq, 24'h0, m_d[31:8]}});
            m_seq = m_seq + 16'd1;
            in_frame = 1;
          end else m_dropinc();
        end
      end else if (w_dat) begin
        if (m_words >= 16'd1024) m_trunc = 1;
        else if (!pend_v) begin pend = m_d; pend_v = 1; end
        else begin
          pend_v = 0;
          if (m_free >= 2) exp_q.push_back('{1'b0, 8'hFF, {m_d, pend}});
          else m_ovf = 1;
        end
        if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
      end else if (w_bad) begin
        m_prot = 1;
      end else if (w_eof || w_sof) begin
        if (w_sof) begin m_prot = 1; m_dropinc(); end
        if (pend_v) begin
          if (m_free >= 2) exp_q.push_back('{1'b0, 8'h0F, {32'h0, pend}});
          else m_ovf = 1;
          pend_v = 0;
        end
        trail_due = 1;
      end
      m_v = link_valid; m_d = link_data; m_k = link_k;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", ob_valid, exp_q.size() != 0);
      chk("fifo_count", fifo_count, exp_q.size());
      chk("frame_seq", frame_seq, m_seq);
      chk("drop_cnt", drop_cnt, m_drop);
      if (exp_q.size() != 0 && ob_valid) begin
        chk("data", ob_data, exp_q[0].data);
        chk("keep", ob_keep, exp_q[0].keep);
        chk("last", ob_last, exp_q[0].last);
      end
    end
  end

  beat_t log_q[$];
  beat_t tlog_q[$];
  always @(negedge clk) begin
    if (ob_valid && ready) log_q.push_back('{ob_last, ob_keep, ob_data});
    if (t_valid) tlog_q.push_back('{t_last, t_keep, t_data});
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k);
    @(posedge clk); #1;
    link_data = d; link_k = k; link_valid = 1'b1;
  endtask
  task automatic sof(input logic [23:0] tag); send({tag, 8'h3C}, 4'b0001); endtask
  task automatic eof();                       send(32'h0000_00DC, 4'b0001); endtask
  task automatic dat(input logic [31:0] x);   send(x, 4'b0000); endtask
  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; link_valid = 1'b0; link_k = '0; end
  endtask

  task automatic chk_beat(input string name, input beat_t b, input logic [63:0] d,
                          input logic [7:0] k, input logic l);
    chk({name, "_data"}, b.data, d);
    chk({name, "_keep"}, b.keep, k);
    chk({name, "_last"}, b.last, l);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ob_valid, 0);
    chk("rst_data", ob_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_seq", frame_seq, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    gap(2);

    // Basic frame with odd word count.
    log_q.delete();
    sof(24'h123456); dat(32'h11); dat(32'h22); dat(32'h33); eof(); gap(8);
    chk("t1_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk_beat("t1_hdr", log_q[0], 64'h0000_0000_0012_3456, 8'hFF, 1'b0);
      chk_beat("t1_d0",  log_q[1], 64'h0000_0022_0000_0011, 8'hFF, 1'b0);
      chk_beat("t1_d1",  log_q[2], 64'h0000_0000_0000_0033, 8'h0F, 1'b0);
      chk_beat("t1_trl", log_q[3], 64'h0000_0000_0000_0003, 8'hFF, 1'b1);
    end
    chk("t1_seq", frame_seq, 1);

    // Empty frame.
    log_q.delete();
    sof(24'hABCDEF); eof(); gap(6);
    chk("t2_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk_beat("t2_hdr", log_q[0], 64'h0001_0000_00AB_CDEF, 8'hFF, 1'b0);
      chk_beat("t2_trl", log_q[1], 64'h0, 8'hFF, 1'b1);
    end

    // SOF with enable low is ignored without counting a drop.
    log_q.delete();
    enable = 1'b0;
    sof(24'h777777); dat(32'h1); eof(); gap(6);
    enable = 1'b1;
    chk("t3_beats", log_q.size(), 0);
    chk("t3_drop", drop_cnt, 0);

    // Overflow with the sink stalled.
    log_q.delete();
    ready = 1'b0;
    sof(24'h000001);
    for (int i = 0; i < 40; i++) dat(32'h100 + i);
    eof(); gap(4);
    chk("t4_full", fifo_count, 16);
    sof(24'h000002); gap(4);
    chk("t4_drop", drop_cnt, 1);
    ready = 1'b1;
    gap(30);
    chk("t4_beats", log_q.size(), 16);
    if (log_q.size() == 16) begin
      chk_beat("t4_hdr", log_q[0], 64'h0002_0000_0000_0001, 8'hFF, 1'b0);
      chk_beat("t4_trl", log_q[15], 64'h0000_0000_0004_0028, 8'hFF, 1'b1);
    end

    // Bad K and an in-frame SOF.
    log_q.delete();
    sof(24'h000007); dat(32'hA); send(32'h0000_0055, 4'b1000); dat(32'hB);
    sof(24'h000008); dat(32'hC); eof(); gap(8);
    chk("t5_beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk_beat("t5_d0",  log_q[1], 64'h0000_000B_0000_000A, 8'hFF, 1'b0);
      chk_beat("t5_trl", log_q[2], 64'h0000_0000_0002_0002, 8'hFF, 1'b1);
    end
    chk("t5_drop", drop_cnt, 2);

    // Reset mid-frame, then a clean frame.
    sof(24'h000009); dat(32'h1); dat(32'h2); dat(32'h3); gap(1);
    rst_n = 1'b0;
    gap(2);
    log_q.delete();
    rst_n = 1'b1;
    gap(1);
    sof(24'h000055); dat(32'h5); dat(32'h6); eof(); gap(8);
    chk("t6_beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk_beat("t6_hdr", log_q[0], 64'h0000_0000_0000_0055, 8'hFF, 1'b0);
      chk_beat("t6_d0",  log_q[1], 64'h0000_0006_0000_0005, 8'hFF, 1'b0);
      chk_beat("t6_trl", log_q[2], 64'h0000_0000_0000_0002, 8'hFF, 1'b1);
    end

    // Truncation on the MAX_WORDS=4 instance.
    tlog_q.delete();
    tsel = 1'b1;
    sof(24'h004444);
    for (int i = 1; i <= 6; i++) dat(i);
    eof(); gap(8);
    tsel = 1'b0;
    chk("t7_beats", tlog_q.size(), 4);
    if (tlog_q.size() == 4) begin
      chk_beat("t7_hdr", tlog_q[0], 64'h0000_0000_0000_4444, 8'hFF, 1'b0);
      chk_beat("t7_d0",  tlog_q[1], 64'h0000_0002_0000_0001, 8'hFF, 1'b0);
      chk_beat("t7_d1",  tlog_q[2], 64'h0000_0004_0000_0003, 8'hFF, 1'b0);
      chk_beat("t7_trl", tlog_q[3], 64'h0000_0000_0001_0006, 8'hFF, 1'b1);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
